dpm_ctrl_multi: RTL and testbench
=================================

Name: dpm_ctrl_multi

Overview:
- Parametrised multi-channel dynamic power-management controller, successor to the single-domain DPM unit.
- Tracks N_CH power domains, each with its own idle/off timers and a wake-latency sequencer.
- Enforces a global budget on simultaneously powered domains and grants wakes round-robin.
- Sits between the domain-activity monitors and the power-switch and clock-gate enables of the user design.

Parameters:
- N_CH, 4, number of power domains (1..15).
- CNT_W, 8, per-channel timer width.
- IDLE_CYC, 8, consecutive non-busy cycles in ACTIVE before moving to IDLE (1..2^CNT_W-1).
- OFF_CYC, 16, consecutive quiet cycles in IDLE before moving to OFF (1..2^CNT_W-1).
- WAKE_LAT, 4, cycles spent in WAKE before ACTIVE (1..2^CNT_W-1).
- MAX_ON, 2, maximum domains not in OFF at once (1..N_CH).

Ports:
- clk  in  1  system clock, all state updated on rising edge.
- rst  in  1  asynchronous, active-high reset.
- busy  in  N_CH  per-domain activity indicator.
- wake_req  in  N_CH  level wake request; held by requester until ready[i]=1.
- sleep_req  in  N_CH  force domain to OFF.
- pwr_en  out  N_CH  power switch enable, 1 when state != OFF.
- clk_en  out  N_CH  clock gate enable, 1 when state == ACTIVE.
- ready  out  N_CH  domain usable; equals clk_en.
- state_o  out  2*N_CH  per-domain state; channel i occupies bits [2i+1:2i].
- on_count  out  4  number of domains not in OFF.

Behaviour:
- State encoding: ACTIVE=00, IDLE=01, OFF=10, WAKE=11.
- All outputs are derived from registered state. No combinational path from inputs to outputs.
- Reset (async assert, sync release):
  - every channel goes to OFF and every timer clears;
  - round-robin pointer goes to 0;
  - pwr_en=clk_en=ready=0, state_o=all 10, on_count=0.
- ACTIVE:
  - sleep_req[i]=1 with wake_req[i]=0 -> OFF next cycle.
  - Otherwise busy[i]=0 increments the timer; busy[i]=1 clears it.
  - The cycle the timer would reach IDLE_CYC -> IDLE, timer cleared. IDLE is therefore entered exactly IDLE_CYC cycles after busy falls.
- IDLE:
  - busy[i] or wake_req[i] -> ACTIVE next cycle, timer cleared.
  - Else sleep_req[i] -> OFF.
  - Else the timer counts; after OFF_CYC cycles -> OFF.
- OFF:
  - wake_req[i] raises a request to the arbiter.
  - A grant requires on_count < MAX_ON.
  - At most one grant per cycle. The arbiter is round-robin from the pointer; after a grant the pointer moves to granted+1 mod N_CH.
  - Granted channel -> WAKE next cycle, timer loaded with WAKE_LAT.
- WAKE:
  - Timer decrements each cycle; the cycle after it reaches 1 -> ACTIVE. WAKE lasts exactly WAKE_LAT cycles.
  - sleep_req and busy are ignored in WAKE.
- on_count is a popcount of registered states != OFF. A channel leaving OFF in the same cycle another enters OFF is judged on the current registered on_count, so the budget is never exceeded.
- Priority rules:
  - wake_req beats sleep_req in ACTIVE and IDLE.
  - A wake_req dropped while in WAKE does not abort the sequence; the domain reaches ACTIVE and then times out normally.
- A mid-sequence reset returns the channel to OFF immediately; no ready pulse is produced.

Optional Feature:
- Macro: DPM_STATS_EN.
- When defined, adds ports stat_sel (in, 4) and stat_cnt (out, 16).
  - Each channel keeps a 16-bit wake counter, incremented on every WAKE->ACTIVE transition and saturating at 0xFFFF.
  - Counters are cleared by rst.
  - stat_cnt is a combinational mux of the counter selected by stat_sel; stat_sel >= N_CH yields 0.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset: after rst=1 then 0, expect state_o=8'b10101010, pwr_en=0, clk_en=0, on_count=0.
- Wake latency (WAKE_LAT=4): wake_req[0]=1 at edge t -> state_o[1:0]=11 and pwr_en[0]=1 from t+1; ready[0]=1 from t+5.
- Timeouts (IDLE_CYC=3, OFF_CYC=5): ch0 ACTIVE, busy[0]=0 from edge t -> IDLE at t+3, OFF at t+8. Separately, busy[0]=1 during IDLE -> ACTIVE next cycle.
- Budget (MAX_ON=2): wake_req=4'b1111 from OFF -> ch0 granted at cycle 1, ch1 at cycle 2; ch2/ch3 stay OFF with on_count=2. Then sleep_req[0] -> ch0 OFF, and ch2 is granted the following cycle.
- Priority/reset:
  - In IDLE, wake_req[1] and sleep_req[1] together -> ACTIVE.
  - rst asserted during ch1 WAKE -> immediate OFF, pwr_en[1]=0 with no clock edge required.
- Stats (DPM_STATS_EN): three full wake cycles on ch2, stat_sel=2 -> stat_cnt=3; stat_sel=7 -> stat_cnt=0.

Source files
------------

// File: rtl/dpm_ctrl_multi.sv
// dpm_ctrl_multi: multi-domain dynamic power-management controller.
// Each domain runs its own ACTIVE/IDLE/OFF/WAKE sequencer with idle, off and
// wake-latency timers; wakes are granted round-robin under a global budget
// on simultaneously powered domains.
// Optional build macro DPM_STATS_EN adds per-domain wake counters readable
// through stat_sel/stat_cnt.
module dpm_ctrl_multi #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned IDLE_CYC = 8,
    parameter int unsigned OFF_CYC  = 16,
    parameter int unsigned WAKE_LAT = 4,
    parameter int unsigned MAX_ON   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   busy,
    input  logic [N_CH-1:0]   wake_req,
    input  logic [N_CH-1:0]   sleep_req,
    output logic [N_CH-1:0]   pwr_en,
    output logic [N_CH-1:0]   clk_en,
    output logic [N_CH-1:0]   ready,
    output logic [2*N_CH-1:0] state_o,
    output logic [3:0]        on_count
`ifdef DPM_STATS_EN
    ,
    input  logic [3:0]        stat_sel,
    output logic [15:0]       stat_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'b00,
        ST_IDLE   = 2'b01,
        ST_OFF    = 2'b10,
        ST_WAKE   = 2'b11
    } state_t;

    localparam logic [CNT_W:0]   IDLE_LIM  = (CNT_W+1)'(IDLE_CYC);
    localparam logic [CNT_W:0]   OFF_LIM   = (CNT_W+1)'(OFF_CYC);
    localparam logic [CNT_W-1:0] WAKE_INIT = CNT_W'(WAKE_LAT);

    state_t            state_q [N_CH];
    state_t            state_d [N_CH];
    logic [CNT_W-1:0]  timer_q [N_CH];
    logic [CNT_W-1:0]  timer_d [N_CH];
    logic [3:0]        ptr_q, ptr_d;
    logic [N_CH-1:0]   grant;
    logic [4:0]        arb_idx;
    logic              found;
    logic [CNT_W:0]    tinc;
    logic [3:0]        on_cnt;

    // Outputs decoded purely from registered state; on_count is a popcount of powered domains.
    always_comb begin
        on_cnt = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            pwr_en[i]        = (state_q[i] != ST_OFF);
            clk_en[i]        = (state_q[i] == ST_ACTIVE);
            state_o[2*i +: 2] = state_q[i];
            on_cnt           = on_cnt + 4'(pwr_en[i]);
        end
        ready    = clk_en;
        on_count = on_cnt;
    end

    // Round-robin wake arbiter: one grant per cycle, judged on the registered budget.
    always_comb begin
        grant   = '0;
        ptr_d   = ptr_q;
        arb_idx = '0;
        found   = 1'b0;
        if (on_cnt < 4'(MAX_ON)) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                arb_idx = 5'(ptr_q) + 5'(k);
                if (arb_idx >= 5'(N_CH)) arb_idx = arb_idx - 5'(N_CH);
                for (int unsigned j = 0; j < N_CH; j++) begin
                    if (!found && (5'(j) == arb_idx) && (state_q[j] == ST_OFF) && wake_req[j]) begin
                        grant[j] = 1'b1;
                        found    = 1'b1;
                        ptr_d    = (j == N_CH - 1) ? 4'd0 : 4'(j + 1);
                    end
                end
            end
        end
    end

    // Per-domain sequencer next state and timer update.
    always_comb begin
        tinc = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            tinc       = {1'b0, timer_q[i]} + (CNT_W+1)'(1);
            case (state_q[i])
                ST_ACTIVE: begin
                    if (sleep_req[i] && !wake_req[i]) begin
                        state_d[i] = ST_OFF;
                        timer_d[i] = '0;
                    end else if (busy[i]) begin
                        timer_d[i] = '0;
                    end else if (tinc == IDLE_LIM) begin
                        state_d[i] = ST_IDLE;
                        timer_d[i] = '0;
                    end else begin
                        timer_d[i] = tinc[CNT_W-1:0];
                    end
                end
                ST_IDLE: begin
                    if (busy[i] || wake_req[i]) begin
                        state_d[i] = ST_ACTIVE;
                        timer_d[i] = '0;
                    end else if (sleep_req[i] || (tinc == OFF_LIM)) begin
                        state_d[i] = ST_OFF;
                        timer_d[i] = '0;
                    end else begin
                        timer_d[i] = tinc[CNT_W-1:0];
                    end
                end
                ST_OFF: begin
                    if (grant[i]) begin
                        state_d[i] = ST_WAKE;
                        timer_d[i] = WAKE_INIT;
                    end
                end
                ST_WAKE: begin
                    if (timer_q[i] <= CNT_W'(1)) begin
                        state_d[i] = ST_ACTIVE;
                        timer_d[i] = '0;
                    end else begin
                        timer_d[i] = timer_q[i] - CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_OFF;
                    timer_d[i] = '0;
                end
            endcase
        end
    end

    // State, timer and arbitration pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_OFF;
                timer_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int unsigned i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end

`ifdef DPM_STATS_EN
    logic [15:0] wake_cnt_q [N_CH];
    logic [15:0] wake_cnt_d [N_CH];

    // Saturating count of completed wake sequences per domain.
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            wake_cnt_d[i] = wake_cnt_q[i];
            if ((state_q[i] == ST_WAKE) && (state_d[i] == ST_ACTIVE) && (wake_cnt_q[i] != 16'hFFFF))
                wake_cnt_d[i] = wake_cnt_q[i] + 16'd1;
        end
    end

    // Wake counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CH; i++) wake_cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) wake_cnt_q[i] <= wake_cnt_d[i];
        end
    end

    // Counter readout mux; out-of-range selects read zero.
    always_comb begin
        stat_cnt = '0;
        for (int unsigned j = 0; j < N_CH; j++) begin
            if (4'(j) == stat_sel) stat_cnt = wake_cnt_q[j];
        end
    end
`endif

endmodule

// File: tb/tb_dpm_ctrl_multi.sv
// Self-checking bench for dpm_ctrl_multi (N_CH=4, IDLE_CYC=3, OFF_CYC=5,
// WAKE_LAT=4, MAX_ON=2). Build with DPM_STATS_EN to include the counter test.
module tb_dpm_ctrl_multi;

    localparam logic [1:0] A = 2'b00, I = 2'b01, O = 2'b10, W = 2'b11;

    typedef struct packed {
        logic [3:0] b;
        logic [3:0] w;
        logic [3:0] s;
        logic [7:0] st;
    } step_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] busy = '0, wake_req = '0, sleep_req = '0;
    logic [3:0] pwr_en, clk_en, ready, on_count;
    logic [7:0] state_o;
`ifdef DPM_STATS_EN
    logic [3:0]  stat_sel = '0;
    logic [15:0] stat_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [23:0] exp_q [$];
    logic [15:0] cnt_q [$];

    always #5 clk = ~clk;

    dpm_ctrl_multi #(
        .N_CH(4), .CNT_W(8), .IDLE_CYC(3), .OFF_CYC(5), .WAKE_LAT(4), .MAX_ON(2)
    ) dut (
        .clk(clk), .rst(rst), .busy(busy), .wake_req(wake_req), .sleep_req(sleep_req),
        .pwr_en(pwr_en), .clk_en(clk_en), .ready(ready), .state_o(state_o), .on_count(on_count)
`ifdef DPM_STATS_EN
        , .stat_sel(stat_sel), .stat_cnt(stat_cnt)
`endif
    );

    function automatic logic [7:0] st4(input logic [1:0] c3, c2, c1, c0);
        return {c3, c2, c1, c0};
    endfunction

    // Expected {state_o, pwr_en, clk_en, ready, on_count} from a per-channel state word.
    function automatic logic [23:0] exp_vec(input logic [7:0] st);
        logic [3:0] p, c, n;
        p = '0; c = '0; n = '0;
        for (int i = 0; i < 4; i++) begin
            p[i] = (st[2*i +: 2] != 2'b10);
            c[i] = (st[2*i +: 2] == 2'b00);
            n    = n + 4'(p[i]);
        end
        return {st, p, c, c, n};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; busy = '0; wake_req = '0; sleep_req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [23:0] e;
        rst = 1'b1;
        tick();
        exp_q.push_back(exp_vec(st4(O, O, O, O)));
        e = exp_q.pop_front();
        checks++;
        if ({state_o, pwr_en, clk_en, ready, on_count} !== e) begin
            errors++;
            $display("FAIL reset_held: got %h want %h", {state_o, pwr_en, clk_en, ready, on_count}, e);
        end
        rst = 1'b0;
        tick();
        exp_q.push_back(exp_vec(st4(O, O, O, O)));
        e = exp_q.pop_front();
        checks++;
        if ({state_o, pwr_en, clk_en, ready, on_count} !== e) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", {state_o, pwr_en, clk_en, ready, on_count}, e);
        end
    endtask

    task automatic test_wake_latency();
        step_t tbl [5];
        logic [23:0] e;
        tbl = '{'{4'h1, 4'h1, 4'h0, st4(O, O, O, W)},
                '{4'h1, 4'h1, 4'h0, st4(O, O, O, W)},
                '{4'h1, 4'h1, 4'h0, st4(O, O, O, W)},
                '{4'h1, 4'h1, 4'h0, st4(O, O, O, W)},
                '{4'h1, 4'h1, 4'h0, st4(O, O, O, A)}};
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            busy = tbl[k].b; wake_req = tbl[k].w; sleep_req = tbl[k].s;
            exp_q.push_back(exp_vec(tbl[k].st));
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({state_o, pwr_en, clk_en, ready, on_count} !== e) begin
                errors++;
                $display("FAIL wake_latency[%0d]: got %h want %h", k + 1, {state_o, pwr_en, clk_en, ready, on_count}, e);
            end
        end
        wake_req = '0;
    endtask

    // Continues from ch0 ACTIVE left by test_wake_latency.
    task automatic test_timeouts();
        step_t tbl [17];
        logic [23:0] e;
        tbl = '{'{4'h0, 4'h0, 4'h0, st4(O, O, O, A)},
                '{4'h0, 4'h0, 4'h0, st4(O, O, O, A)},
                '{4'h0, 4'h0, 4'h0, st4(O, O, O, I)},
                '{4'h0, 4'h0, 4'h0, st4(O, O, O, I)},
                '{4'h0, 4'h0, 4'h0, st4(O, O, O, I)},
                '{4'h0, 4'h0, 4'h0, st4(O, O, O, I)},
                '{4'h0, 4'h0, 4'h0, st4(O, O, O, I)},
                '{4'h0, 4'h0, 4'h0, st4(O, O, O, O)},
                '{4'h1, 4'h1, 4'h0, st4(O, O, O, W)},
                '{4'h1, 4'h1, 4'h0, st4(O, O, O, W)},
                '{4'h1, 4'h1, 4'h0, st4(O, O, O, W)},
                '{4'h1, 4'h1, 4'h0, st4(O, O, O, W)},
                '{4'h1, 4'h1, 4'h0, st4(O, O, O, A)},
                '{4'h0, 4'h0, 4'h0, st4(O, O, O, A)},
                '{4'h0, 4'h0, 4'h0, st4(O, O, O, A)},
                '{4'h0, 4'h0, 4'h0, st4(O, O, O, I)},
                '{4'h1, 4'h0, 4'h0, st4(O, O, O, A)}};
        for (int k = 0; k < 17; k++) begin
            busy = tbl[k].b; wake_req = tbl[k].w; sleep_req = tbl[k].s;
            exp_q.push_back(exp_vec(tbl[k].st));
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({state_o, pwr_en, clk_en, ready, on_count} !== e) begin
                errors++;
                $display("FAIL timeouts[%0d]: got %h want %h", k + 1, {state_o, pwr_en, clk_en, ready, on_count}, e);
            end
        end
    endtask

    task automatic test_budget();
        step_t tbl [10];
        logic [23:0] e;
        tbl = '{'{4'hF, 4'hF, 4'h0, st4(O, O, O, W)},
                '{4'hF, 4'hF, 4'h0, st4(O, O, W, W)},
                '{4'hF, 4'hF, 4'h0, st4(O, O, W, W)},
                '{4'hF, 4'hF, 4'h0, st4(O, O, W, W)},
                '{4'hF, 4'hF, 4'h0, st4(O, O, W, A)},
                '{4'hF, 4'hE, 4'h0, st4(O, O, A, A)},
                '{4'hF, 4'hC, 4'h0, st4(O, O, A, A)},
                '{4'hF, 4'hC, 4'h1, st4(O, O, A, O)},
                '{4'hF, 4'hC, 4'h0, st4(O, W, A, O)},
                '{4'hF, 4'hC, 4'h0, st4(O, W, A, O)}};
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            busy = tbl[k].b; wake_req = tbl[k].w; sleep_req = tbl[k].s;
            exp_q.push_back(exp_vec(tbl[k].st));
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({state_o, pwr_en, clk_en, ready, on_count} !== e) begin
                errors++;
                $display("FAIL budget[%0d]: got %h want %h", k + 1, {state_o, pwr_en, clk_en, ready, on_count}, e);
            end
        end
    endtask

    task automatic test_priority();
        step_t tbl [11];
        logic [23:0] e;
        tbl = '{'{4'h0, 4'h2, 4'h0, st4(O, O, W, O)},
                '{4'h0, 4'h2, 4'h0, st4(O, O, W, O)},
                '{4'h0, 4'h0, 4'h0, st4(O, O, W, O)},
                '{4'h0, 4'h0, 4'h0, st4(O, O, W, O)},
                '{4'h0, 4'h0, 4'h0, st4(O, O, A, O)},
                '{4'h0, 4'h0, 4'h0, st4(O, O, A, O)},
                '{4'h0, 4'h0, 4'h0, st4(O, O, A, O)},
                '{4'h0, 4'h0, 4'h0, st4(O, O, I, O)},
                '{4'h0, 4'h2, 4'h2, st4(O, O, A, O)},
                '{4'h0, 4'h2, 4'h2, st4(O, O, A, O)},
                '{4'h0, 4'h0, 4'h2, st4(O, O, O, O)}};
        apply_reset();
        for (int k = 0; k < 11; k++) begin
            busy = tbl[k].b; wake_req = tbl[k].w; sleep_req = tbl[k].s;
            exp_q.push_back(exp_vec(tbl[k].st));
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({state_o, pwr_en, clk_en, ready, on_count} !== e) begin
                errors++;
                $display("FAIL priority[%0d]: got %h want %h", k + 1, {state_o, pwr_en, clk_en, ready, on_count}, e);
            end
        end
        sleep_req = '0;
    endtask

    task automatic test_reset_mid_wake();
        logic [23:0] e;
        apply_reset();
        wake_req = 4'h2;
        tick();
        tick();
        exp_q.push_back(exp_vec(st4(O, O, W, O)));
        e = exp_q.pop_front();
        checks++;
        if ({state_o, pwr_en, clk_en, ready, on_count} !== e) begin
            errors++;
            $display("FAIL midreset_pre: got %h want %h", {state_o, pwr_en, clk_en, ready, on_count}, e);
        end
        #2;
        rst = 1'b1;
        wake_req = '0;
        #1;
        exp_q.push_back(exp_vec(st4(O, O, O, O)));
        e = exp_q.pop_front();
        checks++;
        if ({state_o, pwr_en, clk_en, ready, on_count} !== e) begin
            errors++;
            $display("FAIL midreset_async: got %h want %h", {state_o, pwr_en, clk_en, ready, on_count}, e);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        exp_q.push_back(exp_vec(st4(O, O, O, O)));
        e = exp_q.pop_front();
        checks++;
        if ({state_o, pwr_en, clk_en, ready, on_count} !== e) begin
            errors++;
            $display("FAIL midreset_after: got %h want %h", {state_o, pwr_en, clk_en, ready, on_count}, e);
        end
    endtask

`ifdef DPM_STATS_EN
    task automatic test_stats();
        logic [15:0] e;
        logic [3:0]  sel_tbl [3];
        logic [15:0] val_tbl [3];
        sel_tbl = '{4'd2, 4'd7, 4'd1};
        val_tbl = '{16'd3, 16'd0, 16'd0};
        apply_reset();
        for (int r = 0; r < 3; r++) begin
            wake_req = 4'h4;
            for (int k = 0; k < 5; k++) tick();
            wake_req  = '0;
            sleep_req = 4'h4;
            tick();
            sleep_req = '0;
        end
        for (int k = 0; k < 3; k++) begin
            stat_sel = sel_tbl[k];
            cnt_q.push_back(val_tbl[k]);
            #1;
            e = cnt_q.pop_front();
            checks++;
            if (stat_cnt !== e) begin
                errors++;
                $display("FAIL stats_sel%0d: got %0d want %0d", sel_tbl[k], stat_cnt, e);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_wake_latency();
        test_timeouts();
        test_budget();
        test_priority();
        test_reset_mid_wake();
`ifdef DPM_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
